// File: rtl/fall_detect_pkg.sv
// Shared types and defaults for the fall detection classifier: state encoding,
// datapath widths and threshold constants.
package fall_detect_pkg;

    localparam int STATE_W = 3;
    localparam int FEAT_W  = 16;
    localparam int CNT_W   = 5;

    typedef enum logic [STATE_W-1:0] {
        MONITOR     = 3'd0,
        FREEFALL    = 3'd1,
        STILL_CHECK = 3'd2,
        ALERT       = 3'd3
    } state_t;

    localparam logic [FEAT_W-1:0] DEF_FF_TH     = 16'd300;
    localparam int                DEF_FF_MIN     = 3;
    localparam logic [FEAT_W-1:0] DEF_IMPACT_TH = 16'd2000;
    localparam int                DEF_IMPACT_WIN = 10;
    localparam logic [FEAT_W-1:0] DEF_STILL_TH  = 16'd100;
    localparam int                DEF_STILL_MIN  = 5;
    localparam int                DEF_STILL_WIN  = 20;

    // Slots of the internal phase counters.
    localparam int NUM_CNT   = 3;
    localparam int CNT_FF    = 0;
    localparam int CNT_WIN   = 1;
    localparam int CNT_STILL = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fall_classifier.sv
// Threshold state machine over the feature stream: free-fall, then impact, then
// stillness raises a latched alert; also keeps a saturating fall count.
module fall_classifier
    import fall_detect_pkg::*;
#(
    parameter logic [FEAT_W-1:0] FF_TH      = DEF_FF_TH,
    parameter int                FF_MIN     = DEF_FF_MIN,
    parameter logic [FEAT_W-1:0] IMPACT_TH  = DEF_IMPACT_TH,
    parameter int                IMPACT_WIN = DEF_IMPACT_WIN,
    parameter logic [FEAT_W-1:0] STILL_TH   = DEF_STILL_TH,
    parameter int                STILL_MIN  = DEF_STILL_MIN,
    parameter int                STILL_WIN  = DEF_STILL_WIN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              feature_valid,
    input  logic [FEAT_W-1:0] feature_mean,
    input  logic [FEAT_W-1:0] feature_std,
    input  logic              alert_ack,
    output logic              fall_alert,
    output logic              fall_event,
    output logic [7:0]        fall_count,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state_reg, state_next;
    logic   alert_reg, alert_next;
    logic   event_reg, event_next;
    logic   count_inc;

    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0] cnt_clr;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic [CNT_W-1:0]   cnt_plus [NUM_CNT];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_phase_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (cnt_inc[gi]),
                .clr     (cnt_clr[gi]),
                .count   (cnt_val[gi])
            );
            assign cnt_plus[gi] = cnt_val[gi] + CNT_W'(1);
        end
    endgenerate

    sat_counter #(.W(8)) u_fall_count (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (count_inc),
        .clr     (1'b0),
        .count   (fall_count)
    );

    logic mean_low, std_impact, std_still;
    assign mean_low   = feature_mean < FF_TH;
    assign std_impact = feature_std > IMPACT_TH;
    assign std_still  = feature_std < STILL_TH;

    always_comb begin
        state_next = state_reg;
        alert_next = alert_reg;
        event_next = 1'b0;
        count_inc  = 1'b0;
        cnt_inc    = '0;
        cnt_clr    = '0;

        if (!enable) begin
            state_next = MONITOR;
            alert_next = 1'b0;
            cnt_clr    = '1;
        end else begin
            case (state_reg)
                MONITOR: begin
                    if (feature_valid) begin
                        if (!mean_low) begin
                            cnt_clr[CNT_FF] = 1'b1;
                        end else if (cnt_plus[CNT_FF] == CNT_W'(FF_MIN)) begin
                            state_next = FREEFALL;
                            cnt_clr    = '1;
                        end else begin
                            cnt_inc[CNT_FF] = 1'b1;
                        end
                    end
                end
                FREEFALL: begin
                    if (feature_valid) begin
                        if (std_impact) begin
                            state_next = STILL_CHECK;
                            cnt_clr    = '1;
                        end else if (cnt_plus[CNT_WIN] == CNT_W'(IMPACT_WIN)) begin
                            state_next = MONITOR;
                            cnt_clr    = '1;
                        end else begin
                            cnt_inc[CNT_WIN] = 1'b1;
                        end
                    end
                end
                STILL_CHECK: begin
                    if (feature_valid) begin
                        // Alert is checked first so it beats a coincident window timeout.
                        if (std_still && (cnt_plus[CNT_STILL] == CNT_W'(STILL_MIN))) begin
                            state_next = ALERT;
                            alert_next = 1'b1;
                            event_next = 1'b1;
                            count_inc  = 1'b1;
                            cnt_clr    = '1;
                        end else if (cnt_plus[CNT_WIN] == CNT_W'(STILL_WIN)) begin
                            state_next = MONITOR;
                            cnt_clr    = '1;
                        end else begin
                            cnt_inc[CNT_WIN] = 1'b1;
                            if (std_still) begin
                                cnt_inc[CNT_STILL] = 1'b1;
                            end else begin
                                cnt_clr[CNT_STILL] = 1'b1;
                            end
                        end
                    end
                end
                ALERT: begin
                    if (alert_ack) begin
                        state_next = MONITOR;
                        alert_next = 1'b0;
                        cnt_clr    = '1;
                    end
                end
                default: begin
                    state_next = MONITOR;
                    alert_next = 1'b0;
                    cnt_clr    = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= MONITOR;
            alert_reg <= 1'b0;
            event_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            alert_reg <= alert_next;
            event_reg <= event_next;
        end
    end

    assign fall_alert = alert_reg;
    assign fall_event = event_reg;
    assign state_dbg  = state_reg;

endmodule

// File: doc/fall_classifier.md
Name: fall_classifier

Overview:
- Downstream consumer of the feature pipeline. Takes the per-window feature_mean / feature_std stream and runs a threshold state machine over it.
- Detects the pattern free-fall → impact → stillness, then raises a latched fall alert that holds until acknowledged.
- Also keeps a saturating count of detected falls for the host or LED logic.

Parameters:
- FF_TH, 16'd300: mean strictly below this counts as a free-fall sample.
- FF_MIN, 3: consecutive free-fall samples required to enter FREEFALL.
- IMPACT_TH, 16'd2000: std strictly above this counts as an impact.
- IMPACT_WIN, 10: max feature samples in FREEFALL waiting for impact.
- STILL_TH, 16'd100: std strictly below this counts as a still sample.
- STILL_MIN, 5: consecutive still samples required to declare a fall.
- STILL_WIN, 20: max feature samples in STILL_CHECK before abandoning.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  classifier enable; low forces idle
- feature_valid  in  1  one-cycle strobe, mean/std valid
- feature_mean  in  16  unsigned window mean of magnitude
- feature_std  in  16  unsigned window std of magnitude
- alert_ack  in  1  clears latched alert
- fall_alert  out  1  latched fall indication
- fall_event  out  1  one-cycle pulse on alert entry
- fall_count  out  8  saturating number of falls detected
- state_dbg  out  3  current state encoding

Behaviour:
- Reset and clock: one clock (clk). Reset is synchronous, active-low, on reset_n.
- Reset values: state=MONITOR, all internal counters 0, fall_alert=0, fall_event=0, fall_count=0, state_dbg=3'd0.
- Registered timing: all outputs are registered. A decision is made on the edge that samples feature_valid=1 and is visible the following cycle.
- Sample gating: in MONITOR, FREEFALL and STILL_CHECK, cycles with feature_valid=0 change nothing.
- Comparisons: all unsigned and strict. Internal counters are 5 bits. Parameters must be at most 31.
- State encoding: MONITOR=0, FREEFALL=1, STILL_CHECK=2, ALERT=3.
- MONITOR:
  - On valid: if mean<FF_TH, ff_cnt++; else ff_cnt=0.
  - When the incremented ff_cnt==FF_MIN → FREEFALL, win_cnt=0, ff_cnt=0.
- FREEFALL:
  - On valid: if std>IMPACT_TH → STILL_CHECK, still_cnt=0, win_cnt=0.
  - Otherwise win_cnt++. When win_cnt reaches IMPACT_WIN → MONITOR.
  - Impact takes priority over timeout on the same sample.
- STILL_CHECK:
  - On valid: win_cnt++. If std<STILL_TH, still_cnt++; else still_cnt=0.
  - When still_cnt reaches STILL_MIN → ALERT. That edge sets fall_alert=1, sets fall_event=1 for exactly one cycle, and increments fall_count unless it is 255.
  - Otherwise, when win_cnt reaches STILL_WIN → MONITOR.
  - Alert takes priority over timeout on the same sample.
- ALERT:
  - feature_valid is ignored.
  - fall_alert is held at 1 until alert_ack=1 is sampled. That edge → MONITOR, fall_alert=0, counters cleared.
  - alert_ack in any other state has no effect and is not remembered.
- fall_event: 0 in every cycle except the single cycle after ALERT entry.
- enable=0, any state:
  - Next edge → MONITOR, counters cleared, fall_alert=0, fall_event=0. fall_count is held.
  - enable has priority over ack and valid. While low, feature samples are dropped.
- Reset mid-operation: reset_n=0 on any edge returns everything to reset values, including fall_count.
- fall_count saturates at 255 and never wraps.
- state_dbg mirrors the state register.

Decomposition:
- Shared package fall_detect_pkg:
  - state enum/localparams (MONITOR, FREEFALL, STILL_CHECK, ALERT) and STATE_W=3;
  - default threshold constants;
  - FEAT_W=16 and CNT_W=5.
- One natural sub-module: sat_counter (parameterised width, inc/clear, saturate at max). Used for fall_count and reusable for ff_cnt, win_cnt and still_cnt.

Test Plan:
- Nominal fall: 3 valid samples mean=200 → FREEFALL; 1 sample std=2500 → STILL_CHECK; 5 samples std=50 → fall_alert=1, fall_event exactly one cycle, fall_count=1, state_dbg=3.
- Broken free-fall: mean=200,200,400,200,200 → stays MONITOR. Then a further mean=200 (third consecutive) → FREEFALL.
- Impact timeout: enter FREEFALL, then 10 samples std=500 → MONITOR. A later std=2500 in MONITOR has no effect.
- Stillness failure: reach STILL_CHECK, then 20 samples alternating std 50/300 → MONITOR, fall_alert stays 0, fall_count unchanged.
- Ack and enable:
  - In ALERT, feature samples leave the state unchanged.
  - alert_ack pulse → MONITOR, fall_alert=0.
  - A second fall with enable dropped for one cycle mid-STILL_CHECK → MONITOR, fall_count still 1.
- Saturation and reset: force 256 falls → fall_count=255. reset_n=0 for one edge mid-FREEFALL → state 0, fall_count 0, all outputs 0.
